// File: rtl/lsu_sram_ctrl_pkg.sv
// Shared types and constants for the LSU-to-external-SRAM sequencer.
`timescale 1ns/1ps

package lsu_sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    // Word index taken from byte address bits [18:2].
    localparam int WORD_ADDR_W = SRAM_ADDR_W - 1;
    // Wait-state counter width; holds WAIT_CYC up to 15.
    localparam int WCNT_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_RSP
    } sram_state_e;

    // Request fields captured on acceptance and held for the whole transaction.
    typedef struct packed {
        logic                   we;
        logic [WORD_ADDR_W-1:0] word;
        logic [31:0]            wdata;
        logic [3:0]             strb;
    } sram_req_t;

    // First state after acceptance: loads always run both halves, stores
    // skip any half whose strobes are all clear.
    function automatic sram_state_e first_phase(input logic we, input logic [3:0] strb);
        if (!we || strb[1:0] != 2'b00) begin
            return S_LO;
        end else if (strb[3:2] != 2'b00) begin
            return S_HI;
        end else begin
            return S_RSP;
        end
    endfunction

    // State following the low-half phase.
    function automatic sram_state_e after_lo(input logic we, input logic [3:0] strb);
        return (!we || strb[3:2] != 2'b00) ? S_HI : S_RSP;
    endfunction

endpackage

// File: rtl/lsu_sram_ctrl.sv
// Splits one 32-bit LSU load/store into two 16-bit asynchronous-SRAM phases
// (low half, then high half) with programmable wait states. All SRAM pins
// come straight from flops; the next pin values are computed from the next
// state so the pins line up with the state they belong to.
`timescale 1ns/1ps

module lsu_sram_ctrl
    import lsu_sram_ctrl_pkg::*;
#(
    // WE_N/OE_N-active cycles per phase; legal range 1..15.
    parameter int WAIT_CYC = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,

    input  logic                   i_req_vld,
    output logic                   o_req_rdy,
    input  logic                   i_req_we,
    input  logic [31:0]            i_req_addr,
    input  logic [31:0]            i_req_wdata,
    input  logic [3:0]             i_req_strb,

    output logic                   o_rsp_vld,
    output logic [31:0]            o_rsp_rdata,

    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_UB_N
);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYC);

    sram_state_e             state_q, state_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    sram_req_t               req_q, req_d;
    logic                    phase_last;

    logic [SRAM_ADDR_W-1:0]  addr_q, addr_d;
    logic                    ce_n_q, ce_n_d;
    logic                    we_n_q, we_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    lb_n_q, lb_n_d;
    logic                    ub_n_q, ub_n_d;
    logic                    dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0]  dq_out_q, dq_out_d;

    logic [SRAM_DATA_W-1:0]  rd_lo_q;
    logic [31:0]             rdata_q;

    // Byte-offset and above-window address bits are not part of the SRAM map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[31:19], i_req_addr[1:0]};

    // Last cycle of a phase: the edge that ends it captures load data.
    assign phase_last = (wcnt_q == WAIT_LAST);

    // Next-state, wait counter and request latch.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        wcnt_d  = wcnt_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_vld) begin
                    req_d   = '{we:    i_req_we,
                                word:  i_req_addr[18:2],
                                wdata: i_req_wdata,
                                strb:  i_req_strb};
                    state_d = first_phase(i_req_we, i_req_strb);
                    wcnt_d  = '0;
                end
            end
            S_LO: begin
                if (phase_last) begin
                    state_d = after_lo(req_q.we, req_q.strb);
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end
            S_HI: begin
                if (phase_last) begin
                    state_d = S_RSP;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // SRAM pin values for the cycle that the next state describes.
    always_comb begin
        logic in_phase;
        logic hi;
        logic strobe_active;
        in_phase      = (state_d == S_LO) || (state_d == S_HI);
        hi            = (state_d == S_HI);
        strobe_active = (wcnt_d != '0);
        ce_n_d        = 1'b1;
        we_n_d        = 1'b1;
        oe_n_d        = 1'b1;
        lb_n_d        = 1'b1;
        ub_n_d        = 1'b1;
        dq_oe_d       = 1'b0;
        addr_d        = addr_q;
        dq_out_d      = dq_out_q;
        if (in_phase) begin
            ce_n_d = 1'b0;
            addr_d = {req_d.word, hi};
            if (req_d.we) begin
                lb_n_d   = ~(hi ? req_d.strb[2] : req_d.strb[0]);
                ub_n_d   = ~(hi ? req_d.strb[3] : req_d.strb[1]);
                dq_oe_d  = 1'b1;
                dq_out_d = hi ? req_d.wdata[31:16] : req_d.wdata[15:0];
                // Cycle 0 of each phase is setup, so WE_N is high there.
                we_n_d   = ~strobe_active;
            end else begin
                lb_n_d   = 1'b0;
                ub_n_d   = 1'b0;
                oe_n_d   = ~strobe_active;
            end
        end
    end

    // State, counter and latched request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            req_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before the edge.
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            req_q   <= req_d;
        end
    end

    // Registered SRAM pins; reset parks the device deselected and the bus released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            addr_q   <= addr_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            lb_n_q   <= lb_n_d;
            ub_n_q   <= ub_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    // Load data capture on the last edge of each phase; the response word
    // only changes when the high half lands, so it is held between loads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_lo_q <= '0;
            rdata_q <= '0;
        end else if (!req_q.we && phase_last) begin
            if (state_q == S_LO) begin
                rd_lo_q <= SRAM_DQ;
            end else if (state_q == S_HI) begin
                rdata_q <= {SRAM_DQ, rd_lo_q};
            end
        end
    end

    assign SRAM_DQ     = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_LB_N   = lb_n_q;
    assign SRAM_UB_N   = ub_n_q;

    assign o_req_rdy   = (state_q == S_IDLE);
    assign o_rsp_vld   = (state_q == S_RSP);
    assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Bench for lsu_sram_ctrl: a WAIT_CYC=1 instance checked every cycle against
// a transaction-level expected pin trace, plus a WAIT_CYC=3 instance checked
// with a directed load.
`timescale 1ns/1ps

module tb_lsu_sram_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // WAIT_CYC = 1 instance
    logic        req_vld, req_we, req_rdy, rsp_vld;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_strb;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;

    // WAIT_CYC = 3 instance
    logic        req_vld3, req_we3, req_rdy3, rsp_vld3;
    logic [31:0] req_addr3, req_wdata3, rsp_rdata3;
    logic [3:0]  req_strb3;
    logic [17:0] sram_addr3;
    wire  [15:0] dq3;
    logic        ce_n3, we_n3, oe_n3, lb_n3, ub_n3;

    lsu_sram_ctrl #(.WAIT_CYC(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_strb(req_strb),
        .o_rsp_vld(rsp_vld), .o_rsp_rdata(rsp_rdata),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    lsu_sram_ctrl #(.WAIT_CYC(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_vld(req_vld3), .o_req_rdy(req_rdy3), .i_req_we(req_we3),
        .i_req_addr(req_addr3), .i_req_wdata(req_wdata3), .i_req_strb(req_strb3),
        .o_rsp_vld(rsp_vld3), .o_rsp_rdata(rsp_rdata3),
        .SRAM_ADDR(sram_addr3), .SRAM_DQ(dq3), .SRAM_CE_N(ce_n3), .SRAM_WE_N(we_n3),
        .SRAM_OE_N(oe_n3), .SRAM_LB_N(lb_n3), .SRAM_UB_N(ub_n3)
    );

    // Asynchronous SRAM models (only the low 4K half-words are populated).
    logic [15:0] mem  [0:4095];
    logic [15:0] mem3 [0:4095];
    logic [15:0] ref_mem [0:4095];

    assign dq  = (!ce_n  && !oe_n  && we_n)  ? mem[sram_addr[11:0]]   : 16'hzzzz;
    assign dq3 = (!ce_n3 && !oe_n3 && we_n3) ? mem3[sram_addr3[11:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[11:0]][7:0]  = dq[7:0];
            if (!ub_n) mem[sram_addr[11:0]][15:8] = dq[15:8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected per-cycle view of the WAIT_CYC=1 instance.
    // ctl = {CE_N, WE_N, OE_N, LB_N, UB_N, req_rdy, rsp_vld}
    typedef struct {
        logic [6:0]  ctl;
        logic        addr_chk;
        logic [17:0] addr;
        logic        dq_chk;
        logic [15:0] dq;
        logic [31:0] rdata;
    } cyc_t;

    localparam logic [6:0] CTL_IDLE = 7'b1111110;
    localparam logic [6:0] CTL_RSP  = 7'b1111101;
    localparam int         W1       = 1;

    cyc_t        exp_q[$];
    logic [31:0] last_rdata = '0;
    bit          model_on = 1'b0;

    // Expands one request into the pin trace it must produce: the accept
    // cycle, WAIT+1 cycles for every half that runs, then the response cycle.
    task automatic model_push(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb);
        cyc_t        c;
        logic [31:0] nxt;
        logic [16:0] word;
        logic [17:0] ha;
        bit          run;
        nxt  = last_rdata;
        word = addr[18:2];
        c = '{ctl: CTL_IDLE, addr_chk: 1'b0, addr: '0, dq_chk: 1'b0, dq: '0, rdata: last_rdata};
        exp_q.push_back(c);
        for (int h = 0; h < 2; h++) begin
            run = !we || (strb[2*h +: 2] != 2'b00);
            if (!run) continue;
            ha = {word, h[0]};
            if (!we) nxt[16*h +: 16] = ref_mem[ha[11:0]];
            for (int k = 0; k <= W1; k++) begin
                c.ctl      = {1'b0, !(we && k > 0), !(!we && k > 0),
                              we ? !strb[2*h] : 1'b0, we ? !strb[2*h+1] : 1'b0, 1'b0, 1'b0};
                c.addr_chk = 1'b1;
                c.addr     = ha;
                c.dq_chk   = we;
                c.dq       = wdata[16*h +: 16];
                c.rdata    = last_rdata;
                exp_q.push_back(c);
            end
            if (we) begin
                if (strb[2*h])   ref_mem[ha[11:0]][7:0]  = wdata[16*h +: 8];
                if (strb[2*h+1]) ref_mem[ha[11:0]][15:8] = wdata[16*h+8 +: 8];
            end
        end
        c = '{ctl: CTL_RSP, addr_chk: 1'b0, addr: '0, dq_chk: 1'b0, dq: '0, rdata: nxt};
        exp_q.push_back(c);
        last_rdata = nxt;
    endtask

    // Per-cycle compare against the expected trace (idle view when empty).
    cyc_t e;
    always @(negedge clk) begin
        if (model_on && rst_n) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{ctl: CTL_IDLE, addr_chk: 1'b0, addr: '0, dq_chk: 1'b0, dq: '0, rdata: last_rdata};
            check("ctl", {25'd0, ce_n, we_n, oe_n, lb_n, ub_n, req_rdy, rsp_vld}, {25'd0, e.ctl});
            if (e.addr_chk) check("sram_addr", {14'd0, sram_addr}, {14'd0, e.addr});
            if (e.dq_chk)   check("store_dq", {16'd0, dq}, {16'd0, e.dq});
            check("rsp_rdata", rsp_rdata, e.rdata);
        end
    end

    // Issues one request in the current IDLE cycle and measures the edges
    // from acceptance to the edge that ends the response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int exp_lat, input string tag);
        int n;
        bit seen;
        if (model_on) model_push(we, addr, wdata, strb);
        req_vld = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_strb = strb;
        @(posedge clk); #1;
        req_vld = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_strb = 4'($urandom);
        n = 0; seen = 1'b0;
        while (n <= 40) begin
            if (rsp_vld) seen = 1'b1;
            else if (seen) break;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    // Directed WAIT_CYC=3 load: latency, address stability and strobe width.
    task automatic w3_load();
        int n, lo_cnt, hi_cnt, bad_addr, oe_lo, oe_hi, we_low;
        bit seen;
        logic [31:0] got;
        n = 0; lo_cnt = 0; hi_cnt = 0; bad_addr = 0; oe_lo = 0; oe_hi = 0; we_low = 0;
        seen = 1'b0; got = '0;
        req_vld3 = 1'b1; req_we3 = 1'b0; req_addr3 = 32'h0000_0600; req_strb3 = 4'h0;
        @(posedge clk); #1;
        req_vld3 = 1'b0; req_addr3 = $urandom;
        while (n <= 40) begin
            if (!we_n3) we_low++;
            if (!ce_n3) begin
                if (sram_addr3 == 18'h00300) begin
                    lo_cnt++;
                    if (!oe_n3) oe_lo++;
                end else if (sram_addr3 == 18'h00301) begin
                    hi_cnt++;
                    if (!oe_n3) oe_hi++;
                end else begin
                    bad_addr++;
                end
            end
            if (rsp_vld3) begin
                seen = 1'b1;
                got  = rsp_rdata3;
            end else if (seen) begin
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        check("w3_latency", n, 9);
        check("w3_lo_cycles", lo_cnt, 4);
        check("w3_hi_cycles", hi_cnt, 4);
        check("w3_bad_addr", bad_addr, 0);
        check("w3_oe_lo_cycles", oe_lo, 3);
        check("w3_oe_hi_cycles", oe_hi, 3);
        check("w3_we_low_cycles", we_low, 0);
        check("w3_rdata", got, 32'hC3C3_5A5A);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A00;
            ref_mem[i] = 16'(i) ^ 16'h5A00;
            mem3[i]    = 16'h0000;
        end
        mem[12'h200] = 16'h1234; ref_mem[12'h200] = 16'h1234;
        mem[12'h201] = 16'hABCD; ref_mem[12'h201] = 16'hABCD;
        mem3[12'h300] = 16'h5A5A;
        mem3[12'h301] = 16'hC3C3;
        req_vld = 1'b0;  req_we = 1'b0;  req_addr = '0;  req_wdata = '0;  req_strb = '0;
        req_vld3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; req_strb3 = '0;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        check("reset_ctl", {25'd0, ce_n, we_n, oe_n, lb_n, ub_n, req_rdy, rsp_vld}, {25'd0, CTL_IDLE});
        check("reset_addr", {14'd0, sram_addr}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        model_on = 1'b1;

        // Load of half-words 0x200/0x201.
        do_req(1'b0, 32'h0000_0400, 32'h0, 4'h0, 5, "ld_basic");
        check("ld_basic_rdata", rsp_rdata, 32'hABCD_1234);

        // Full-word store and readback.
        do_req(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 5, "st_full");
        check("st_full_mem4", {16'd0, mem[4]}, 32'h0000_BEEF);
        check("st_full_mem5", {16'd0, mem[5]}, 32'h0000_DEAD);
        do_req(1'b0, 32'h0000_0008, 32'h0, 4'hF, 5, "ld_full");
        check("ld_full_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Single byte in the high half: only HI runs, low lane only.
        do_req(1'b1, 32'h0000_0008, 32'h0077_0000, 4'h4, 3, "st_byte");
        check("st_byte_mem5", {16'd0, mem[5]}, 32'h0000_DE77);
        check("st_byte_mem4", {16'd0, mem[4]}, 32'h0000_BEEF);
        do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, 5, "ld_byte");
        check("ld_byte_rdata", rsp_rdata, 32'hDE77_BEEF);

        // Store with no strobes: no SRAM access at all.
        do_req(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 1, "st_none");
        check("st_none_mem4", {16'd0, mem[4]}, 32'h0000_BEEF);
        check("st_none_mem5", {16'd0, mem[5]}, 32'h0000_DE77);

        // Low half only.
        do_req(1'b1, 32'h0000_0010, 32'h0000_5566, 4'h3, 3, "st_lo");
        check("st_lo_mem8", {16'd0, mem[8]}, 32'h0000_5566);
        check("st_lo_mem9", {16'd0, mem[9]}, {16'd0, ref_mem[9]});

        // Address bits outside [18:2] have no effect.
        do_req(1'b0, 32'hFFF8_0403, 32'h0, 4'hF, 5, "ld_alias");
        check("ld_alias_rdata", rsp_rdata, 32'hABCD_1234);

        // Asynchronous reset during the WE-active cycle of the HI phase.
        model_on = 1'b0;
        req_vld = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020;
        req_wdata = 32'h1122_3344; req_strb = 4'hF;
        @(posedge clk); #1;
        req_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pre_we_n", {31'd0, we_n}, 32'd0);
        check("rst_pre_addr", {14'd0, sram_addr}, 32'h0000_0011);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {25'd0, ce_n, we_n, oe_n, lb_n, ub_n, req_rdy, rsp_vld}, {25'd0, CTL_IDLE});
        check("rst_mid_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_mid_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_lo_written", {16'd0, mem[12'h010]}, 32'h0000_3344);
        check("rst_hi_untouched", {16'd0, mem[12'h011]}, {16'd0, ref_mem[12'h011]});
        check("rst_post_rdy", {31'd0, req_rdy}, 32'd1);
        exp_q.delete();
        last_rdata = '0;
        model_on = 1'b1;
        do_req(1'b0, 32'h0000_0400, 32'h0, 4'h0, 5, "ld_after_rst");
        check("ld_after_rst_rdata", rsp_rdata, 32'hABCD_1234);

        // WAIT_CYC = 3 instance.
        w3_load();

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
